// File: rtl/num_conv.sv
// Registered binary-to-Gray encoder with a Gray-to-binary round-trip decoder, one pipeline stage.
// Optional round-trip checker enabled by defining NUM_CONV_CHECK_EN.
module num_conv #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [n-1:0] bin,
  output logic         out_valid,
  output logic [n-1:0] bin_2_gray,
  output logic [n-1:0] gray_2_bin,
  output logic         err
);

  logic [n-1:0] w_gray;
  logic [n-1:0] w_dec;
  logic [n-1:0] r_gray;
  logic [n-1:0] r_dec;
  logic         r_valid;

  assign w_gray = bin ^ (bin >> 1);

  // Decode is a prefix XOR running from the MSB down through the Gray word.
  always_comb begin
    w_dec        = '0;
    w_dec[n-1]   = w_gray[n-1];
    for (int i = n - 2; i >= 0; i--) begin
      w_dec[i] = w_dec[i+1] ^ w_gray[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gray  <= '0;
      r_dec   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_gray <= w_gray;
        r_dec  <= w_dec;
      end
    end
  end

  assign out_valid  = r_valid;
  assign bin_2_gray = r_gray;
  assign gray_2_bin = r_dec;

`ifdef NUM_CONV_CHECK_EN
  logic [n-1:0] r_bin;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin <= '0;
    end else if (in_valid) begin
      r_bin <= bin;
    end
  end

  // Shadow copy of the sample lets the decoded word be compared against its source.
  assign err = r_valid & (r_dec != r_bin);
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_num_conv.sv
// Self-checking bench for num_conv: directed vector table, sweep, and randomized traffic
// checked against a reflected-Gray lookup table built by mirroring.
module tb_num_conv;

  localparam int N    = 4;
  localparam int SIZE = 1 << N;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [N-1:0] bin;
  logic         out_valid;
  logic [N-1:0] bin_2_gray;
  logic [N-1:0] gray_2_bin;
  logic         err;

  int nChecks = 0;
  int nFails  = 0;

  logic [N-1:0] grayTable [SIZE];
  logic [N-1:0] expGray  = '0;
  logic [N-1:0] expDec   = '0;
  logic         expValid = 1'b0;

  typedef struct {
    bit           r;
    bit           v;
    logic [N-1:0] b;
    bit           ev;
    logic [N-1:0] eg;
    logic [N-1:0] ed;
  } vector_t;

  vector_t vecs [10];

  always #5 clk = ~clk;

  num_conv #(.n(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .bin       (bin),
    .out_valid (out_valid),
    .bin_2_gray(bin_2_gray),
    .gray_2_bin(gray_2_bin),
    .err       (err)
  );

  // Reflected Gray code: each new bit doubles the list by appending its mirror with that bit set.
  function automatic void buildTable();
    int size = 1;
    grayTable[0] = '0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < size; j++) begin
        grayTable[size + j] = grayTable[size - 1 - j] | (N'(1) << k);
      end
      size = size * 2;
    end
  endfunction

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [N-1:0] b);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    bin      = b;
    @(posedge clk);
    if (r) begin
      expGray  = '0;
      expDec   = '0;
      expValid = 1'b0;
    end else if (v) begin
      expGray  = grayTable[b];
      expDec   = b;
      expValid = 1'b1;
    end else begin
      expValid = 1'b0;
    end
    #1;
  endtask

  task automatic checkOutput(input string tag, input bit ev, input logic [N-1:0] eg,
                             input logic [N-1:0] ed);
    check({tag, " valid"}, N'(out_valid), N'(ev));
    check({tag, " gray"}, bin_2_gray, eg);
    check({tag, " bin"}, gray_2_bin, ed);
    check({tag, " err"}, N'(err), '0);
  endtask

  initial begin
    logic [N-1:0] prevGray;
    logic [N-1:0] rb;
    bit           rv;

    buildTable();
    rst      = 1'b1;
    in_valid = 1'b0;
    bin      = '0;

    vecs[0] = '{1, 0, 4'd0,  0, 4'd0,  4'd0};
    vecs[1] = '{1, 1, 4'd3,  0, 4'd0,  4'd0};
    vecs[2] = '{0, 1, 4'd5,  1, 4'd7,  4'd5};
    vecs[3] = '{0, 1, 4'd15, 1, 4'd8,  4'd15};
    vecs[4] = '{0, 1, 4'd8,  1, 4'd12, 4'd8};
    vecs[5] = '{0, 1, 4'd0,  1, 4'd0,  4'd0};
    vecs[6] = '{0, 1, 4'd6,  1, 4'd5,  4'd6};
    vecs[7] = '{0, 0, 4'd9,  0, 4'd5,  4'd6};
    vecs[8] = '{1, 1, 4'd6,  0, 4'd0,  4'd0};
    vecs[9] = '{0, 0, 4'd6,  0, 4'd0,  4'd0};

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].r, vecs[i].v, vecs[i].b);
      checkOutput($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eg, vecs[i].ed);
    end

    // Full sweep including the wrap from all-ones back to zero.
    prevGray = grayTable[SIZE-1];
    for (int b = 0; b <= SIZE; b++) begin
      applyStimulus(1'b0, 1'b1, N'(b % SIZE));
      checkOutput($sformatf("sweep%0d", b), expValid, expGray, expDec);
      if (b > 0) begin
        check($sformatf("sweep%0d onebit", b), N'($countones(bin_2_gray ^ prevGray)), N'(1));
      end
      prevGray = bin_2_gray;
    end

    // Unknown input while idle must not leak into the registered outputs.
    applyStimulus(1'b0, 1'b1, 4'd11);
    checkOutput("preX", expValid, expGray, expDec);
    applyStimulus(1'b0, 1'b0, 'x);
    checkOutput("xhold", expValid, expGray, expDec);

    for (int i = 0; i < 32; i++) begin
      rb = N'($urandom);
      rv = ($urandom_range(0, 3) != 0);
      applyStimulus(1'b0, rv, rb);
      checkOutput($sformatf("rand%0d", i), expValid, expGray, expDec);
    end

    applyStimulus(1'b1, 1'b1, 4'd13);
    checkOutput("finalrst", expValid, expGray, expDec);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
